// File: rtl/statki_pkg.sv
// Shared constants and types for the battleship game blocks.
// Holds global program_state codes, board geometry and the shot evaluator FSM encoding.
package statki_pkg;

  localparam logic [3:0] PS_IDLE          = 4'd0;
  localparam logic [3:0] PS_PLACING_SHIPS = 4'd3;
  localparam logic [3:0] PS_FINDING_SHIPS = 4'd4;
  localparam logic [3:0] PS_GAME_ENDING   = 4'd6;

  localparam int BOARD_XPOS  = 192;
  localparam int BOARD_YPOS  = 112;
  localparam int SQUARE_SIZE = 48;
  localparam int BOARD_DIM   = 8;

  localparam logic [6:0] HITS_MAX = 7'd127;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_EVAL,
    S_HOLD,
    S_DONE
  } eval_state_t;

  // Linear cell index, computed at 7 bits so out-of-board coordinates stay detectable.
  function automatic logic [6:0] cell_index(input logic [3:0] x, input logic [3:0] y, input int dim);
    logic [6:0] idx;
    idx = 7'(x) + 7'(dim) * 7'(y);
    return idx;
  endfunction

endpackage

// File: rtl/shot_evaluator_if.sv
// Signal bundle between the game controller side and shot_evaluator.
// master drives the shot/board inputs, slave is the evaluator itself.
interface shot_evaluator_if;

  logic [3:0]  program_state;
  logic [3:0]  board_size;
  logic        finished_move;
  logic [3:0]  shot_x;
  logic [3:0]  shot_y;
  logic [63:0] player1_ships;
  logic [63:0] player2_ships;
  logic [6:0]  ship_cells;

  logic        active_player;
  logic        shot_valid;
  logic        shot_hit;
  logic        result_show;
  logic [6:0]  p1_hits;
  logic [6:0]  p2_hits;
  logic        winner;
  logic        game_over;

  modport master (
    output program_state, board_size, finished_move, shot_x, shot_y,
           player1_ships, player2_ships, ship_cells,
    input  active_player, shot_valid, shot_hit, result_show,
           p1_hits, p2_hits, winner, game_over
  );

  modport slave (
    input  program_state, board_size, finished_move, shot_x, shot_y,
           player1_ships, player2_ships, ship_cells,
    output active_player, shot_valid, shot_hit, result_show,
           p1_hits, p2_hits, winner, game_over
  );

endinterface

// File: rtl/shot_evaluator_hold_timer.sv
// Loadable down-counter with a done flag; stops at zero.
// Used for the result display window and the HUD blanking logic.
module hold_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/shot_evaluator.sv
// Evaluates committed shots against the opponent's ship map, keeps score and turn,
// and declares the winner once a player has hit every ship cell.
module shot_evaluator #(
  parameter int RESULT_HOLD = 60,
  parameter int BOARD_DIM   = 8
) (
  input logic             clk,
  input logic             rst,
  shot_evaluator_if.slave bus
);

  import statki_pkg::*;

  localparam int HOLD_W = $clog2(RESULT_HOLD + 1);

  eval_state_t state_reg;
  logic [3:0]  x_reg;
  logic [3:0]  y_reg;
  logic        player_reg;

  logic        active_player_reg;
  logic        shot_valid_reg;
  logic        shot_hit_reg;
  logic        result_show_reg;
  logic [6:0]  p1_hits_reg;
  logic [6:0]  p2_hits_reg;
  logic        winner_reg;
  logic        game_over_reg;

  logic        in_play;
  logic        clear_req;
  logic [63:0] target;
  logic [6:0]  idx;
  logic        hit;
  logic [6:0]  shooter_hits;
  logic [6:0]  shooter_next;
  logic        timer_done;

  assign in_play   = (bus.program_state == PS_FINDING_SHIPS);
  assign clear_req = (bus.program_state == PS_IDLE) || (bus.program_state == PS_PLACING_SHIPS);

  always_comb begin
    target       = player_reg ? bus.player1_ships : bus.player2_ships;
    idx          = cell_index(x_reg, y_reg, BOARD_DIM);
    hit          = 1'b0;
    // Off-board shots are misses even when the map happens to have that bit set.
    if ((x_reg < bus.board_size) && (y_reg < bus.board_size) && (idx < 7'd64)) begin
      hit = target[idx[5:0]];
    end
    shooter_hits = player_reg ? p2_hits_reg : p1_hits_reg;
    shooter_next = (shooter_hits == HITS_MAX) ? shooter_hits : shooter_hits + 7'd1;
  end

  hold_timer #(
    .WIDTH(HOLD_W)
  ) u_hold_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (state_reg == S_EVAL),
    .load_value(HOLD_W'(RESULT_HOLD - 1)),
    .en        (state_reg == S_HOLD),
    .done      (timer_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg         <= S_IDLE;
      x_reg             <= '0;
      y_reg             <= '0;
      player_reg        <= 1'b0;
      active_player_reg <= 1'b0;
      shot_valid_reg    <= 1'b0;
      shot_hit_reg      <= 1'b0;
      result_show_reg   <= 1'b0;
      p1_hits_reg       <= '0;
      p2_hits_reg       <= '0;
      winner_reg        <= 1'b0;
      game_over_reg     <= 1'b0;
    end else begin
      shot_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          result_show_reg <= 1'b0;
          if (clear_req) begin
            p1_hits_reg       <= '0;
            p2_hits_reg       <= '0;
            game_over_reg     <= 1'b0;
            winner_reg        <= 1'b0;
            shot_hit_reg      <= 1'b0;
            active_player_reg <= 1'b0;
          end
          if (in_play) begin
            state_reg <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (!in_play) begin
            state_reg <= S_IDLE;
          end else if (bus.finished_move) begin
            x_reg      <= bus.shot_x;
            y_reg      <= bus.shot_y;
            player_reg <= active_player_reg;
            state_reg  <= S_EVAL;
          end
        end

        S_EVAL: begin
          if (!in_play) begin
            state_reg <= S_IDLE;
          end else begin
            shot_hit_reg   <= hit;
            shot_valid_reg <= 1'b1;
            if (hit) begin
              if (player_reg) begin
                p2_hits_reg <= shooter_next;
              end else begin
                p1_hits_reg <= shooter_next;
              end
            end
            if (hit && (shooter_next == bus.ship_cells)) begin
              winner_reg    <= player_reg;
              game_over_reg <= 1'b1;
              state_reg     <= S_DONE;
            end else begin
              result_show_reg <= 1'b1;
              state_reg       <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (!in_play) begin
            result_show_reg <= 1'b0;
            state_reg       <= S_IDLE;
          end else if (timer_done) begin
            result_show_reg <= 1'b0;
            // A hit earns the shooter another turn.
            if (!shot_hit_reg) begin
              active_player_reg <= ~active_player_reg;
            end
            state_reg <= S_WAIT;
          end
        end

        S_DONE: begin
          if (clear_req) begin
            state_reg <= S_IDLE;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.active_player = active_player_reg;
  assign bus.shot_valid    = shot_valid_reg;
  assign bus.shot_hit      = shot_hit_reg;
  assign bus.result_show   = result_show_reg;
  assign bus.p1_hits       = p1_hits_reg;
  assign bus.p2_hits       = p2_hits_reg;
  assign bus.winner        = winner_reg;
  assign bus.game_over     = game_over_reg;

endmodule

// File: tb/tb_shot_evaluator.sv
// Scoreboard bench for shot_evaluator: directed shots push expected results,
// a negedge monitor pops and compares on every shot_valid pulse.
module tb_shot_evaluator;

  import statki_pkg::*;

  localparam int HOLD = 60;

  typedef struct packed {
    logic       hit;
    logic [6:0] p1;
    logic [6:0] p2;
    logic       go;
    logic       win;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shot_evaluator_if bus();

  shot_evaluator #(
    .RESULT_HOLD(HOLD),
    .BOARD_DIM  (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input logic [3:0] x, input logic [3:0] y, input exp_t e);
    bus.shot_x        = x;
    bus.shot_y        = y;
    bus.finished_move = 1'b1;
    q.push_back(e);
    tick();
    bus.finished_move = 1'b0;
  endtask

  // Starts one cycle after finished_move was sampled; runs to the cycle after the hold window.
  task automatic hold_check(input string tag, input logic ap_before, input logic ap_after, input bit poke);
    for (int i = 0; i < HOLD; i++) begin
      if (poke && i == 10) bus.finished_move = 1'b1;
      tick();
      bus.finished_move = 1'b0;
    end
    check({tag, "_show_last"}, 32'(bus.result_show), 32'd1);
    check({tag, "_ap_last"}, 32'(bus.active_player), 32'(ap_before));
    tick();
    check({tag, "_show_off"}, 32'(bus.result_show), 32'd0);
    check({tag, "_ap_after"}, 32'(bus.active_player), 32'(ap_after));
    check({tag, "_drained"}, 32'(q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_active_player"}, 32'(bus.active_player), 32'd0);
    check({tag, "_shot_valid"},    32'(bus.shot_valid),    32'd0);
    check({tag, "_shot_hit"},      32'(bus.shot_hit),      32'd0);
    check({tag, "_result_show"},   32'(bus.result_show),   32'd0);
    check({tag, "_p1_hits"},       32'(bus.p1_hits),       32'd0);
    check({tag, "_p2_hits"},       32'(bus.p2_hits),       32'd0);
    check({tag, "_winner"},        32'(bus.winner),        32'd0);
    check({tag, "_game_over"},     32'(bus.game_over),     32'd0);
  endtask

  always @(negedge clk) begin
    if (bus.shot_valid) begin
      if (q.size() == 0) begin
        check("unexpected_shot_valid", 32'(bus.shot_valid), 32'd0);
      end else begin
        mon_e = q.pop_front();
        $display("shot: hit=%0d p1=%0d p2=%0d game_over=%0d winner=%0d (exp %0d %0d %0d %0d %0d)",
                 bus.shot_hit, bus.p1_hits, bus.p2_hits, bus.game_over, bus.winner,
                 mon_e.hit, mon_e.p1, mon_e.p2, mon_e.go, mon_e.win);
        check("mon_shot_hit",  32'(bus.shot_hit),  32'(mon_e.hit));
        check("mon_p1_hits",   32'(bus.p1_hits),   32'(mon_e.p1));
        check("mon_p2_hits",   32'(bus.p2_hits),   32'(mon_e.p2));
        check("mon_game_over", 32'(bus.game_over), 32'(mon_e.go));
        check("mon_winner",    32'(bus.winner),    32'(mon_e.win));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.program_state = PS_IDLE;
    bus.board_size    = 4'd8;
    bus.finished_move = 1'b0;
    bus.shot_x        = 4'd0;
    bus.shot_y        = 4'd0;
    bus.player1_ships = 64'd0;
    bus.player2_ships = 64'd0;
    bus.ship_cells    = 7'd3;
    bus.player2_ships[10] = 1'b1;   // (2,1)
    bus.player2_ships[20] = 1'b1;   // (4,2)
    bus.player1_ships[6]  = 1'b1;   // (6,0)
    bus.player1_ships[9]  = 1'b1;   // (1,1)

    rst = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b1;
    bus.program_state = PS_PLACING_SHIPS;
    repeat (2) tick();
    bus.program_state = PS_FINDING_SHIPS;
    repeat (2) tick();

    // Player 1 hits (2,1) and keeps the turn.
    fire(4'd2, 4'd1, '{hit: 1'b1, p1: 7'd1, p2: 7'd0, go: 1'b0, win: 1'b0});
    hold_check("hit1", 1'b0, 1'b0, 1'b0);

    // Player 1 misses at (0,0); turn passes.
    fire(4'd0, 4'd0, '{hit: 1'b0, p1: 7'd1, p2: 7'd0, go: 1'b0, win: 1'b0});
    hold_check("miss1", 1'b0, 1'b1, 1'b0);

    // Player 2 hits (1,1) on player 1's map.
    fire(4'd1, 4'd1, '{hit: 1'b1, p1: 7'd1, p2: 7'd1, go: 1'b0, win: 1'b0});
    hold_check("hit2", 1'b1, 1'b1, 1'b0);

    // Off-board shot on a set bit is a miss.
    bus.board_size = 4'd5;
    fire(4'd6, 4'd0, '{hit: 1'b0, p1: 7'd1, p2: 7'd1, go: 1'b0, win: 1'b0});
    hold_check("offboard", 1'b1, 1'b0, 1'b0);

    // Hit with an extra finished_move during the hold window.
    fire(4'd2, 4'd1, '{hit: 1'b1, p1: 7'd2, p2: 7'd1, go: 1'b0, win: 1'b0});
    hold_check("drop", 1'b0, 1'b0, 1'b1);

    // Third hit reaches ship_cells: game over, player 1 wins.
    fire(4'd4, 4'd2, '{hit: 1'b1, p1: 7'd3, p2: 7'd1, go: 1'b1, win: 1'b0});
    repeat (2) tick();
    check("win_game_over", 32'(bus.game_over), 32'd1);
    check("win_show", 32'(bus.result_show), 32'd0);
    bus.finished_move = 1'b1;
    tick();
    bus.finished_move = 1'b0;
    repeat (5) tick();
    check("done_p1_hits", 32'(bus.p1_hits), 32'd3);
    check("done_game_over", 32'(bus.game_over), 32'd1);
    bus.program_state = PS_GAME_ENDING;
    repeat (3) tick();
    check("ending_game_over", 32'(bus.game_over), 32'd1);
    check("ending_p2_hits", 32'(bus.p2_hits), 32'd1);
    bus.program_state = PS_IDLE;
    repeat (2) tick();
    check_all_zero("cleared");

    // Reset during the hold window after a miss.
    bus.program_state = PS_FINDING_SHIPS;
    repeat (2) tick();
    fire(4'd0, 4'd0, '{hit: 1'b0, p1: 7'd0, p2: 7'd0, go: 1'b0, win: 1'b0});
    repeat (12) tick();
    check("midrst_show_before", 32'(bus.result_show), 32'd1);
    rst = 1'b0;
    tick();
    check_all_zero("midrst");
    rst = 1'b1;
    repeat (HOLD + 10) tick();
    check("midrst_no_toggle", 32'(bus.active_player), 32'd0);
    check("midrst_show_after", 32'(bus.result_show), 32'd0);

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
